// File: rtl/fifo2pe_dispatch_pkg.sv
// rtl/fifo2pe_dispatch_pkg.sv - shared types, constants and helpers for the FIFO-to-Edge-PE dispatcher
//
// Contents:
//   `Num_Edge_PE / `PACKET_SIZE : global sizing defines (fallbacks if not already defined)
//   com_packet                  : {valid, packet} record used on packet buses
//   DISPATCH_DST_LSB            : LSB of the destination PE-id field inside a packet
//   dispatch_state_t            : dispatcher FSM states
//   pe_id_of()                  : extracts the destination PE id from a default-sized packet

`ifndef Num_Edge_PE
`define Num_Edge_PE 4
`endif
`ifndef PACKET_SIZE
`define PACKET_SIZE 64
`endif

package fifo2pe_dispatch_pkg;

   typedef struct packed {
      logic                    valid;
      logic [`PACKET_SIZE-1:0] packet;
   } com_packet;

   localparam int DISPATCH_DST_LSB = 0;
   localparam int PE_ID_W          = (`Num_Edge_PE > 1) ? $clog2(`Num_Edge_PE) : 1;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1
   } dispatch_state_t;

   function automatic logic [PE_ID_W-1:0] pe_id_of(input logic [`PACKET_SIZE-1:0] packet);
      return packet[DISPATCH_DST_LSB +: PE_ID_W];
   endfunction

endpackage

// File: rtl/fifo2pe_dispatch_pkt_queue2.sv
// rtl/fifo2pe_dispatch_pkt_queue2.sv - 2-entry circular packet queue with push/pop/flush
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   flush             : synchronous clear of count and pointers (below reset, above push/pop)
//   push, push_data   : write push_data at the tail
//   pop               : retire the head entry
//   count             : current occupancy (0..2)
//   count_next        : occupancy after this cycle's push/pop/flush
//   head              : head entry (raw storage, qualified by count != 0)

module pkt_queue2 #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [1:0]   count,
   output logic [1:0]   count_next,
   output logic [W-1:0] head
);

   logic [W-1:0] mem [2];
   logic         head_ptr;
   logic         tail_ptr;
   logic         do_push;
   logic         do_pop;

   assign do_pop  = pop && (count != 2'd0);
   // The issue logic keeps the queue from overflowing; the guard only protects storage.
   assign do_push = push && ((count != 2'd2) || do_pop);
   assign head    = mem[head_ptr];

   always_comb begin
      count_next = count;
      if (reset || flush) begin
         count_next = 2'd0;
      end else begin
         count_next = count + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         count    <= 2'd0;
         head_ptr <= 1'b0;
         tail_ptr <= 1'b0;
      end else begin
         if (do_push) begin
            mem[tail_ptr] <= push_data;
            tail_ptr      <= ~tail_ptr;
         end
         if (do_pop) begin
            head_ptr <= ~head_ptr;
         end
         count <= count_next;
      end
   end

endmodule

// File: rtl/fifo2pe_dispatch.sv
// rtl/fifo2pe_dispatch.sv - pops packets from the packet FIFO and unicasts them to Edge PEs
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   fifo_empty        : packet FIFO has nothing to read
//   fifo_rd_en        : FIFO pop request; data returns on fifo_packet one cycle later
//   fifo_packet       : FIFO read data
//   replay_iter_flag  : synchronous flush for iteration replay
//   pe_ready          : per-PE accept
//   pe_valid          : one-hot offer to the destination PE of the head packet
//   pe_packet         : head packet, broadcast to all PEs, qualified by pe_valid
//   fifo_stall        : queue full, packet controller must pause
//   iter_done         : one-cycle pulse after a last-of-iteration packet is accepted

module fifo2pe_dispatch
   import fifo2pe_dispatch_pkg::*;
#(
   parameter int NUM_PE   = `Num_Edge_PE,
   parameter int PACKET_W = `PACKET_SIZE,
   parameter int DST_LSB  = DISPATCH_DST_LSB,
   parameter int LAST_BIT = PACKET_W - 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                fifo_empty,
   output logic                fifo_rd_en,
   input  logic [PACKET_W-1:0] fifo_packet,
   input  logic                replay_iter_flag,
   input  logic [NUM_PE-1:0]   pe_ready,
   output logic [NUM_PE-1:0]   pe_valid,
   output logic [PACKET_W-1:0] pe_packet,
   output logic                fifo_stall,
   output logic                iter_done
);

   localparam int ID_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

   dispatch_state_t     state;
   logic                inflight;
   logic [1:0]          count;
   logic [1:0]          count_next;
   logic [PACKET_W-1:0] head;
   logic [ID_W-1:0]     head_id;
   logic                head_present;
   logic                id_in_range;
   logic                transfer;
   logic                pop;
   logic                push;
   logic [2:0]          credit;

   assign head_present = (count != 2'd0);
   assign head_id      = head[DST_LSB +: ID_W];
   assign id_in_range  = (int'(head_id) < NUM_PE);

   // Offer decode works only from queue registers, so pe_ready never feeds pe_valid/pe_packet.
   always_comb begin
      pe_valid = '0;
      if (head_present && id_in_range) begin
         pe_valid[head_id] = 1'b1;
      end
   end

   assign pe_packet = head_present ? head : '0;

   assign transfer = |(pe_valid & pe_ready);
   // A head addressed to a non-existent PE is discarded in one cycle.
   assign pop      = transfer || (head_present && !id_in_range);

   // Entries already held plus the read in flight, minus what leaves this cycle.
   assign credit     = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
   assign fifo_rd_en = !reset && !replay_iter_flag && (state == ST_RUN) &&
                       !fifo_empty && (credit < 3'd2);

   // Returning data is only accepted in RUN; a read issued before a flush is dropped.
   assign push = inflight && (state == ST_RUN);

   pkt_queue2 #(
      .W (PACKET_W)
   ) u_queue (
      .clk        (clk),
      .reset      (reset),
      .flush      (replay_iter_flag),
      .push       (push),
      .push_data  (fifo_packet),
      .pop        (pop),
      .count      (count),
      .count_next (count_next),
      .head       (head)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_RUN;
         inflight   <= 1'b0;
         fifo_stall <= 1'b0;
         iter_done  <= 1'b0;
      end else if (replay_iter_flag) begin
         state      <= ST_FLUSH;
         inflight   <= 1'b0;
         fifo_stall <= 1'b0;
         iter_done  <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               inflight   <= fifo_rd_en;
               fifo_stall <= (count_next == 2'd2);
               iter_done  <= transfer && head[LAST_BIT];
            end
            ST_FLUSH: begin
               // Single dead cycle: reads were blocked, so nothing is in flight afterwards.
               state      <= ST_RUN;
               inflight   <= 1'b0;
               fifo_stall <= 1'b0;
               iter_done  <= 1'b0;
            end
            default: begin
               state      <= ST_RUN;
               inflight   <= 1'b0;
               fifo_stall <= 1'b0;
               iter_done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo2pe_dispatch.sv
// tb/tb_fifo2pe_dispatch.sv - self-checking bench for fifo2pe_dispatch
module tb_fifo2pe_dispatch;
   localparam int NUM_PE   = 4;
   localparam int PACKET_W = 64;
   localparam int ID_W     = 2;
   localparam int LAST_BIT = 63;

   logic                clk = 1'b0;
   logic                reset;
   logic                fifo_empty;
   logic                fifo_rd_en;
   logic [PACKET_W-1:0] fifo_packet;
   logic                replay_iter_flag;
   logic [NUM_PE-1:0]   pe_ready;
   logic [NUM_PE-1:0]   pe_valid;
   logic [PACKET_W-1:0] pe_packet;
   logic                fifo_stall;
   logic                iter_done;

   always #5 clk = ~clk;

   fifo2pe_dispatch #(
      .NUM_PE   (NUM_PE),
      .PACKET_W (PACKET_W),
      .DST_LSB  (0),
      .LAST_BIT (LAST_BIT)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .fifo_empty       (fifo_empty),
      .fifo_rd_en       (fifo_rd_en),
      .fifo_packet      (fifo_packet),
      .replay_iter_flag (replay_iter_flag),
      .pe_ready         (pe_ready),
      .pe_valid         (pe_valid),
      .pe_packet        (pe_packet),
      .fifo_stall       (fifo_stall),
      .iter_done        (iter_done)
   );

   typedef struct {
      logic       rd;
      logic [3:0] valid;
      logic       stall;
      logic       done;
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic [63:0] fq[$];
   logic [63:0] mq[$];
   bit          m_inflight, m_flush, m_stall, m_iter;
   bit          have_ret;
   logic [63:0] ret_data;
   bit          toggle_empty;

   logic        s_rd, s_stall, s_iter;
   logic [3:0]  s_valid;
   logic [63:0] s_packet;
   int          n_deliv, n_iter, n_rd, n_rd_empty, last_xfer_cyc, iter_cyc;
   logic [63:0] last_deliv;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [63:0] mk(input int dst, input bit last);
      logic [63:0] p;
      p = {$urandom, $urandom};
      p[ID_W-1:0] = dst[ID_W-1:0];
      p[LAST_BIT] = last;
      return p;
   endfunction

   // One clock cycle: drive FIFO side, compare against the queue-level model, advance.
   task automatic tick();
      logic [3:0]  e_valid;
      logic [63:0] e_packet;
      bit          e_pop, e_rd;
      int          d;
      fifo_empty  = (fq.size() == 0) || (toggle_empty && cyc[0]);
      fifo_packet = have_ret ? ret_data : {$urandom, $urandom};
      #1;
      e_valid  = '0;
      e_packet = '0;
      e_pop    = 0;
      if (mq.size() > 0) begin
         d        = int'(mq[0][ID_W-1:0]);
         e_packet = mq[0];
         if (d < NUM_PE) begin
            e_valid[d] = 1'b1;
            e_pop      = pe_ready[d];
         end else begin
            e_pop = 1;
         end
      end
      e_rd = !reset && !replay_iter_flag && !m_flush && !fifo_empty &&
             ((mq.size() + int'(m_inflight) - int'(e_pop)) < 2);

      chk("rd_en", 64'(fifo_rd_en), 64'(e_rd));
      chk("pe_valid", 64'(pe_valid), 64'(e_valid));
      chk("pe_packet", pe_packet, e_packet);
      chk("fifo_stall", 64'(fifo_stall), 64'(m_stall));
      chk("iter_done", 64'(iter_done), 64'(m_iter));

      s_rd = fifo_rd_en; s_valid = pe_valid; s_packet = pe_packet;
      s_stall = fifo_stall; s_iter = iter_done;
      if (fifo_rd_en === 1'b1) n_rd++;
      if (fifo_rd_en === 1'b1 && fifo_empty) n_rd_empty++;
      if (iter_done === 1'b1) begin n_iter++; iter_cyc = cyc; end
      if (|(pe_valid & pe_ready)) begin
         n_deliv++;
         last_deliv = pe_packet;
         if (pe_packet[LAST_BIT]) last_xfer_cyc = cyc;
      end

      if (reset) begin
         mq.delete(); m_inflight = 0; m_flush = 0; m_stall = 0; m_iter = 0;
      end else if (replay_iter_flag) begin
         mq.delete(); m_inflight = 0; m_flush = 1; m_stall = 0; m_iter = 0;
      end else begin
         m_iter = e_pop && (e_valid != 0) && e_packet[LAST_BIT];
         if (e_pop) void'(mq.pop_front());
         if (m_inflight && !m_flush) mq.push_back(fifo_packet);
         m_stall    = (mq.size() == 2);
         m_inflight = e_rd;
         m_flush    = 0;
      end

      have_ret = 0;
      if (fifo_rd_en === 1'b1 && !fifo_empty && fq.size() > 0) begin
         ret_data = fq.pop_front();
         have_ret = 1;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      reset = 1; replay_iter_flag = 0; pe_ready = '0;
      run(2);
      reset = 0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t        tbl[6];
      logic [63:0] p0, pnew;
      int          t;

      reset = 1; replay_iter_flag = 0; pe_ready = '0; toggle_empty = 0;
      fifo_empty = 1; fifo_packet = '0; have_ret = 0;
      @(negedge clk);
      do_reset();

      // Reset state
      chk("rst_rd", 64'(s_rd), 64'd0);
      chk("rst_valid", 64'(s_valid), 64'd0);
      chk("rst_packet", s_packet, 64'd0);
      chk("rst_stall", 64'(s_stall), 64'd0);
      chk("rst_done", 64'(s_iter), 64'd0);
      run(1);

      // 1. Basic unicast: dst 0,1,2 with all PEs ready
      tbl[0] = '{1'b1, 4'b0000, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 4'b0000, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 4'b0001, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 4'b0010, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 4'b0100, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 4'b0000, 1'b0, 1'b0};
      pe_ready = 4'hf;
      for (int i = 0; i < 3; i++) fq.push_back(mk(i, 0));
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("tbl%0d_rd", i), 64'(s_rd), 64'(tbl[i].rd));
         chk($sformatf("tbl%0d_valid", i), 64'(s_valid), 64'(tbl[i].valid));
         chk($sformatf("tbl%0d_stall", i), 64'(s_stall), 64'(tbl[i].stall));
         chk($sformatf("tbl%0d_done", i), 64'(s_iter), 64'(tbl[i].done));
      end

      // 2. Backpressure on PE 1
      pe_ready = 4'b1101;
      p0 = mk(1, 0);
      fq.push_back(p0);
      for (int i = 0; i < 3; i++) fq.push_back(mk(1, 0));
      n_rd = 0;
      run(10);
      chk("bp_issues", 64'(n_rd), 64'd2);
      chk("bp_stall", 64'(s_stall), 64'd1);
      chk("bp_head", s_packet, p0);
      pe_ready = 4'hf;
      n_deliv = 0;
      tick();
      tick();
      chk("bp_stall_drop", 64'(s_stall), 64'd0);
      t = 0;
      while (n_deliv < 4 && t < 30) begin tick(); t++; end
      chk("bp_delivered", 64'(n_deliv), 64'd4);

      // 3. fifo_empty toggling every cycle
      toggle_empty = 1; n_deliv = 0; n_rd_empty = 0;
      for (int i = 0; i < 6; i++) fq.push_back(mk($urandom_range(0, 3), 0));
      run(30);
      toggle_empty = 0;
      chk("te_delivered", 64'(n_deliv), 64'd6);
      chk("te_rd_while_empty", 64'(n_rd_empty), 64'd0);
      chk("te_fifo_drained", 64'(fq.size()), 64'd0);

      // 4. Last flag on 5th packet, dst 3
      n_iter = 0; last_xfer_cyc = -10; iter_cyc = -20;
      for (int i = 0; i < 4; i++) fq.push_back(mk($urandom_range(0, 2), 0));
      fq.push_back(mk(3, 1));
      run(15);
      chk("last_pulses", 64'(n_iter), 64'd1);
      chk("last_timing", 64'(iter_cyc), 64'(last_xfer_cyc + 1));

      // 5a. Flush with a full queue
      pe_ready = '0; n_deliv = 0;
      for (int i = 0; i < 3; i++) fq.push_back(mk(i, 0));
      t = 0;
      while (s_stall !== 1'b1 && t < 10) begin tick(); t++; end
      chk("fl_full_reached", 64'(s_stall), 64'd1);
      replay_iter_flag = 1;
      tick();
      replay_iter_flag = 0;
      tick();
      chk("fl_valid", 64'(s_valid), 64'd0);
      chk("fl_stall", 64'(s_stall), 64'd0);
      chk("fl_rd_blocked", 64'(s_rd), 64'd0);
      pe_ready = 4'hf;
      run(8);
      chk("fl_resume", 64'(n_deliv), 64'd1);

      // 5b. Flush with one entry held and one read in flight
      pe_ready = '0; n_deliv = 0;
      for (int i = 0; i < 3; i++) fq.push_back(mk(3, 0));
      p0 = fq[2];
      run(2);
      replay_iter_flag = 1;
      tick();
      replay_iter_flag = 0;
      tick();
      chk("fl2_valid", 64'(s_valid), 64'd0);
      pe_ready = 4'hf;
      run(8);
      chk("fl2_count", 64'(n_deliv), 64'd1);
      chk("fl2_pkt", last_deliv, p0);

      // 6. Reset while offering to PE 2
      pe_ready = '0;
      fq.push_back(mk(2, 0));
      fq.push_back(mk(2, 0));
      t = 0;
      while (s_valid !== 4'b0100 && t < 10) begin tick(); t++; end
      chk("rs_offer_seen", 64'(s_valid), 64'(4'b0100));
      reset = 1;
      tick();
      tick();
      chk("rs_rd", 64'(s_rd), 64'd0);
      chk("rs_valid", 64'(s_valid), 64'd0);
      chk("rs_packet", s_packet, 64'd0);
      chk("rs_stall", 64'(s_stall), 64'd0);
      chk("rs_done", 64'(s_iter), 64'd0);
      reset = 0;
      fq.delete();
      pnew = mk(1, 0);
      fq.push_back(pnew);
      pe_ready = 4'hf;
      n_deliv = 0;
      t = 0;
      while (n_deliv < 1 && t < 10) begin tick(); t++; end
      chk("rs_first_pkt", last_deliv, pnew);

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         pe_ready         = 4'($urandom);
         replay_iter_flag = ($urandom_range(0, 59) == 0);
         reset            = ($urandom_range(0, 299) == 0);
         if (i % 200 == 0) toggle_empty = $urandom_range(0, 1) == 1;
         if (fq.size() < 8 && $urandom_range(0, 1) == 1)
            fq.push_back(mk($urandom_range(0, 3), $urandom_range(0, 7) == 0));
         tick();
      end
      reset = 0; replay_iter_flag = 0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
